// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register for the cpu2 core: selects the write-back value,
// feeds the register file and EX forwarding, emits the commit record and retire count.
//
// state  | meaning
// RUN    | hltPending=0: instructions are captured normally
// DRAIN  | hltPending=1, hlt=0: HALT sits in WB, later MEM slots are discarded
// HALTED | hlt=1: core stopped until rst
module mem_wb_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  input  logic [15:0]      mem_pc,
  input  logic [15:0]      mem_inst,
  input  logic             mem_reg_write,
  input  logic [3:0]       mem_dst,
  input  logic [15:0]      mem_alu_result,
  input  logic             mem_mem_read,
  input  logic             mem_mem_write,
  input  logic [15:0]      mem_store_data,
  input  logic [15:0]      mem_load_data,
  input  logic             mem_halt,
  input  logic             mem_stall,
  input  logic             flush,
  output logic             wb_valid,
  output logic [15:0]      wb_pc,
  output logic [15:0]      wb_inst,
  output logic             wb_reg_write,
  output logic [3:0]       wb_dst,
  output logic [15:0]      wb_data,
  output logic             wb_mem_read,
  output logic             wb_mem_write,
  output logic [15:0]      wb_mem_addr,
  output logic [15:0]      wb_mem_data,
  output logic             fwd_valid,
  output logic [3:0]       fwd_dst,
  output logic [15:0]      fwd_data,
  output logic             hlt,
  output logic [CNT_W-1:0] retired
);

  logic hltPending;
  logic take;

  assign take = mem_valid & ~mem_stall & ~flush & ~hltPending;

  assign fwd_valid = wb_reg_write;
  assign fwd_dst   = wb_dst;
  assign fwd_data  = wb_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid     <= 1'b0;
      wb_pc        <= '0;
      wb_inst      <= '0;
      wb_reg_write <= 1'b0;
      wb_dst       <= '0;
      wb_data      <= '0;
      wb_mem_read  <= 1'b0;
      wb_mem_write <= 1'b0;
      wb_mem_addr  <= '0;
      wb_mem_data  <= '0;
      hltPending   <= 1'b0;
      hlt          <= 1'b0;
      retired      <= '0;
    end else begin
      wb_valid     <= take;
      // R0 is hardwired zero and HALT never writes a register
      wb_reg_write <= take & mem_reg_write & (mem_dst != 4'd0) & ~mem_halt;
      wb_mem_read  <= take & mem_mem_read;
      wb_mem_write <= take & mem_mem_write;
      if (take) begin
        wb_pc       <= mem_pc;
        wb_inst     <= mem_inst;
        wb_dst      <= mem_dst;
        wb_data     <= mem_mem_read ? mem_load_data : mem_alu_result;
        wb_mem_addr <= mem_alu_result;
        wb_mem_data <= mem_store_data;
      end
      if (take & mem_halt) hltPending <= 1'b1;
      // hltPending is sticky, so hlt follows it one edge later and stays set
      hlt <= hltPending;
      if (wb_valid & ~hlt) retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed vector table, a halt-under-stall sequence,
// and randomized traffic checked against a commit-level reference model.
module tb_mem_wb_stage;

  typedef struct {
    logic valid, stall, flush, halt, rw, mr, mw;
    logic [3:0] dst;
    logic [15:0] pc, inst, alu, sd, ld;
  } in_t;

  typedef struct {
    logic valid, rw, mr, mw, hlt;
    logic [3:0] dst;
    logic [15:0] pc, inst, data, addr, sd;
    int ret;
  } exp_t;

  typedef struct {
    logic rst;
    in_t  in;
    exp_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_halt, mem_stall, flush;
  logic [15:0] mem_pc, mem_inst, mem_alu_result, mem_store_data, mem_load_data;
  logic [3:0] mem_dst;
  logic wb_valid, wb_reg_write, wb_mem_read, wb_mem_write, fwd_valid, hlt;
  logic [15:0] wb_pc, wb_inst, wb_data, wb_mem_addr, wb_mem_data, fwd_data;
  logic [3:0] wb_dst, fwd_dst;
  logic [31:0] retired;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_inst(mem_inst),
    .mem_reg_write(mem_reg_write), .mem_dst(mem_dst), .mem_alu_result(mem_alu_result),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_store_data(mem_store_data), .mem_load_data(mem_load_data),
    .mem_halt(mem_halt), .mem_stall(mem_stall), .flush(flush),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_inst(wb_inst),
    .wb_reg_write(wb_reg_write), .wb_dst(wb_dst), .wb_data(wb_data),
    .wb_mem_read(wb_mem_read), .wb_mem_write(wb_mem_write),
    .wb_mem_addr(wb_mem_addr), .wb_mem_data(wb_mem_data),
    .fwd_valid(fwd_valid), .fwd_dst(fwd_dst), .fwd_data(fwd_data),
    .hlt(hlt), .retired(retired)
  );

  function automatic in_t mkIn(input logic v, s, f, h, rw, mr, mw, input logic [3:0] dst,
                               input logic [15:0] pc, inst, alu, sd, ld);
    in_t x;
    x.valid = v; x.stall = s; x.flush = f; x.halt = h; x.rw = rw; x.mr = mr; x.mw = mw;
    x.dst = dst; x.pc = pc; x.inst = inst; x.alu = alu; x.sd = sd; x.ld = ld;
    return x;
  endfunction

  function automatic exp_t mkExp(input logic v, rw, mr, mw, h, input logic [3:0] dst,
                                 input logic [15:0] pc, inst, data, addr, sd, input int ret);
    exp_t e;
    e.valid = v; e.rw = rw; e.mr = mr; e.mw = mw; e.hlt = h; e.dst = dst;
    e.pc = pc; e.inst = inst; e.data = data; e.addr = addr; e.sd = sd; e.ret = ret;
    return e;
  endfunction

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  task automatic applyCycle(input logic r, input in_t x);
    @(negedge clk);
    rst = r;
    mem_valid = x.valid; mem_stall = x.stall; flush = x.flush; mem_halt = x.halt;
    mem_reg_write = x.rw; mem_mem_read = x.mr; mem_mem_write = x.mw; mem_dst = x.dst;
    mem_pc = x.pc; mem_inst = x.inst; mem_alu_result = x.alu;
    mem_store_data = x.sd; mem_load_data = x.ld;
    @(posedge clk);
    #1;
  endtask

  // Data fields are only meaningful after a capture or a reset.
  task automatic checkOut(input string tag, input exp_t e, input logic chkData);
    cmp({tag, ".wb_valid"}, 32'(wb_valid), 32'(e.valid));
    cmp({tag, ".wb_reg_write"}, 32'(wb_reg_write), 32'(e.rw));
    cmp({tag, ".fwd_valid"}, 32'(fwd_valid), 32'(e.rw));
    cmp({tag, ".wb_mem_read"}, 32'(wb_mem_read), 32'(e.mr));
    cmp({tag, ".wb_mem_write"}, 32'(wb_mem_write), 32'(e.mw));
    cmp({tag, ".hlt"}, 32'(hlt), 32'(e.hlt));
    cmp({tag, ".retired"}, retired, 32'(e.ret));
    if (chkData) begin
      cmp({tag, ".wb_pc"}, 32'(wb_pc), 32'(e.pc));
      cmp({tag, ".wb_inst"}, 32'(wb_inst), 32'(e.inst));
      cmp({tag, ".wb_dst"}, 32'(wb_dst), 32'(e.dst));
      cmp({tag, ".fwd_dst"}, 32'(fwd_dst), 32'(e.dst));
      cmp({tag, ".wb_data"}, 32'(wb_data), 32'(e.data));
      cmp({tag, ".fwd_data"}, 32'(fwd_data), 32'(e.data));
      cmp({tag, ".wb_mem_addr"}, 32'(wb_mem_addr), 32'(e.addr));
      cmp({tag, ".wb_mem_data"}, 32'(wb_mem_data), 32'(e.sd));
    end
  endtask

  // Reference model: tracks commits as a count of accepted instructions and
  // the age of an accepted HALT, rather than mirroring the register stage.
  exp_t m;
  int accCnt;
  int haltAge;
  logic mChk;

  task automatic modelStep(input logic r, input in_t x);
    logic acc;
    if (r) begin
      m = mkExp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      accCnt = 0;
      haltAge = -1;
      mChk = 1'b1;
    end else begin
      acc = x.valid && !x.stall && !x.flush && (haltAge < 0);
      if (haltAge >= 0) haltAge++;
      if (acc && x.halt) haltAge = 0;
      if (acc) begin
        accCnt++;
        m = mkExp(1, x.rw && (x.dst != 0) && !x.halt, x.mr, x.mw, 0, x.dst, x.pc, x.inst,
                  x.mr ? x.ld : x.alu, x.alu, x.sd, 0);
      end else begin
        m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0;
      end
      m.hlt = (haltAge >= 1);
      m.ret = accCnt - (acc ? 1 : 0);
      mChk = acc;
    end
  endtask

  vec_t vecs[17];
  in_t idle;
  exp_t zero;

  initial begin
    idle = mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    zero = mkExp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[0]  = '{1'b1, idle, zero};
    vecs[1]  = '{1'b1, idle, zero};
    vecs[2]  = '{1'b0, mkIn(1,0,0,0,1,0,0,4'd3,16'h0010,16'h1301,16'h1234,16'h0000,16'h0000),
                 mkExp(1,1,0,0,0,4'd3,16'h0010,16'h1301,16'h1234,16'h1234,16'h0000,0)};
    vecs[3]  = '{1'b0, mkIn(1,0,0,0,1,0,0,4'd5,16'h0012,16'h1502,16'hBEEF,16'h0000,16'h0000),
                 mkExp(1,1,0,0,0,4'd5,16'h0012,16'h1502,16'hBEEF,16'hBEEF,16'h0000,1)};
    vecs[4]  = '{1'b0, mkIn(1,0,0,0,1,1,0,4'd2,16'h0014,16'h2240,16'h0040,16'h0000,16'hCAFE),
                 mkExp(1,1,1,0,0,4'd2,16'h0014,16'h2240,16'hCAFE,16'h0040,16'h0000,2)};
    vecs[5]  = '{1'b0, mkIn(1,0,0,0,0,0,1,4'd0,16'h0016,16'h3042,16'h0042,16'h00AA,16'h1111),
                 mkExp(1,0,0,1,0,4'd0,16'h0016,16'h3042,16'h0042,16'h0042,16'h00AA,3)};
    vecs[6]  = '{1'b0, mkIn(1,0,0,0,1,0,0,4'd0,16'h0018,16'h4000,16'hFFFF,16'h0000,16'h0000),
                 mkExp(1,0,0,0,0,4'd0,16'h0018,16'h4000,16'hFFFF,16'hFFFF,16'h0000,4)};
    vecs[7]  = '{1'b0, mkIn(1,1,0,0,1,0,0,4'd9,16'h001A,16'h5900,16'h5555,16'h0000,16'h0000),
                 mkExp(0,0,0,0,0,0,0,0,0,0,0,5)};
    vecs[8]  = vecs[7];
    vecs[9]  = '{1'b0, mkIn(1,0,1,1,0,0,0,4'd0,16'h001A,16'hF000,16'h0000,16'h0000,16'h0000),
                 mkExp(0,0,0,0,0,0,0,0,0,0,0,5)};
    vecs[10] = '{1'b0, mkIn(1,0,0,0,1,0,0,4'd1,16'h001C,16'h6101,16'h0001,16'h0000,16'h0000),
                 mkExp(1,1,0,0,0,4'd1,16'h001C,16'h6101,16'h0001,16'h0001,16'h0000,5)};
    vecs[11] = '{1'b0, mkIn(1,0,0,1,1,0,0,4'd7,16'h0020,16'hF000,16'h0099,16'h0000,16'h0000),
                 mkExp(1,0,0,0,0,4'd7,16'h0020,16'hF000,16'h0099,16'h0099,16'h0000,6)};
    vecs[12] = '{1'b0, mkIn(1,0,0,0,1,0,0,4'd4,16'h0022,16'h7404,16'h4444,16'h0000,16'h0000),
                 mkExp(0,0,0,0,1,0,0,0,0,0,0,7)};
    vecs[13] = '{1'b0, mkIn(1,0,0,0,1,0,0,4'd4,16'h0024,16'h7404,16'h4444,16'h0000,16'h0000),
                 mkExp(0,0,0,0,1,0,0,0,0,0,0,7)};
    vecs[14] = '{1'b1, vecs[13].in, zero};
    vecs[15] = '{1'b0, mkIn(1,0,0,0,1,0,0,4'd6,16'h0030,16'h8606,16'h6666,16'h0000,16'h0000),
                 mkExp(1,1,0,0,0,4'd6,16'h0030,16'h8606,16'h6666,16'h6666,16'h0000,0)};
    vecs[16] = '{1'b0, idle, mkExp(0,0,0,0,0,0,0,0,0,0,0,1)};

    for (int i = 0; i < 17; i++) begin
      applyCycle(vecs[i].rst, vecs[i].in);
      checkOut($sformatf("vec%0d", i), vecs[i].e, vecs[i].e.valid || vecs[i].rst);
    end

    // HALT held while stalled must not arm halt until it is actually taken
    applyCycle(1'b1, idle);
    checkOut("hs.reset", zero, 1'b1);
    applyCycle(1'b0, mkIn(1,1,0,1,0,0,0,4'd0,16'h0040,16'hF000,16'h0000,16'h0000,16'h0000));
    checkOut("hs.stalled", mkExp(0,0,0,0,0,0,0,0,0,0,0,0), 1'b0);
    applyCycle(1'b0, mkIn(1,0,0,1,0,0,0,4'd0,16'h0040,16'hF000,16'h0000,16'h0000,16'h0000));
    checkOut("hs.taken", mkExp(1,0,0,0,0,4'd0,16'h0040,16'hF000,16'h0000,16'h0000,16'h0000,0), 1'b1);
    applyCycle(1'b0, mkIn(1,0,0,0,1,0,0,4'd2,16'h0042,16'h1200,16'h0002,16'h0000,16'h0000));
    checkOut("hs.halted", mkExp(0,0,0,0,1,0,0,0,0,0,0,1), 1'b0);
    applyCycle(1'b0, idle);
    checkOut("hs.frozen", mkExp(0,0,0,0,1,0,0,0,0,0,0,1), 1'b0);

    // Randomized traffic against the reference model
    modelStep(1'b1, idle);
    applyCycle(1'b1, idle);
    checkOut("rnd.reset", m, mChk);
    for (int c = 0; c < 600; c++) begin
      in_t x;
      logic r;
      r = ($urandom_range(0, 59) == 0);
      x.valid = ($urandom_range(0, 3) != 0);
      x.stall = ($urandom_range(0, 4) == 0);
      x.flush = ($urandom_range(0, 7) == 0);
      x.halt  = ($urandom_range(0, 29) == 0);
      x.rw    = 1'($urandom);
      x.mr    = ($urandom_range(0, 2) == 0);
      x.mw    = !x.mr && ($urandom_range(0, 3) == 0);
      x.dst   = 4'($urandom);
      x.pc    = 16'($urandom);
      x.inst  = 16'($urandom);
      x.alu   = 16'($urandom);
      x.sd    = 16'($urandom);
      x.ld    = 16'($urandom);
      modelStep(r, x);
      applyCycle(r, x);
      checkOut($sformatf("rnd%0d", c), m, mChk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Pipeline register and commit logic between the memory stage and the register file of the 16-bit cpu2 core. It captures one instruction per cycle from MEM and selects the write-back value (load data or ALU result). It drives the register-file write port and the EX forwarding path, and produces the architectural commit record (PC, instruction, register/memory effects, halt) that the cpu2 bench traces. It also counts retired instructions and makes halt sticky once a halt instruction reaches write-back.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  core clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- mem_valid  in  1  MEM slot holds a real instruction
- mem_pc  in  16  PC of the MEM instruction
- mem_inst  in  16  instruction word
- mem_reg_write  in  1  instruction writes a register
- mem_dst  in  4  destination register
- mem_alu_result  in  16  ALU result; also the memory address
- mem_mem_read  in  1  instruction is a load
- mem_mem_write  in  1  instruction is a store
- mem_store_data  in  16  store data
- mem_load_data  in  16  data-memory read data, valid in the same cycle
- mem_halt  in  1  instruction is HALT
- mem_stall  in  1  MEM cannot hand off this cycle
- flush  in  1  kill the MEM instruction
- wb_valid  out  1  WB register holds a committing instruction
- wb_pc, wb_inst  out  16  committed PC / instruction
- wb_reg_write  out  1  register-file write enable
- wb_dst  out  4  register-file write index
- wb_data  out  16  register-file write data
- wb_mem_read, wb_mem_write  out  1  committed load / store flags
- wb_mem_addr, wb_mem_data  out  16  committed address / store data
- fwd_valid  out  1  forwarding source valid (equals wb_reg_write)
- fwd_dst  out  4  equals wb_dst
- fwd_data  out  16  equals wb_data
- hlt  out  1  sticky halt
- retired  out  CNT_W  count of committed instructions

## Operation
- Capture condition: `take = mem_valid & ~mem_stall & ~flush & ~hlt_pending`.
- On `take`:
  - Load all WB fields from the mem_* inputs and set wb_valid=1.
  - wb_data = mem_mem_read ? mem_load_data : mem_alu_result.
- Otherwise: load a bubble. wb_valid=0; wb_reg_write, wb_mem_read and wb_mem_write are 0. Data fields may hold stale values.
- Write suppression:
  - wb_reg_write = captured mem_reg_write & (mem_dst != 0). R0 is hardwired zero.
  - wb_reg_write is forced to 0 when the captured instruction is HALT.
- Forwarding: fwd_* are combinational copies of the WB register, with no added logic.
- Halt handling:
  - hlt_pending is set when HALT is captured (same edge as capture).
  - hlt rises one cycle later, in the cycle after HALT's WB cycle, and stays 1 until rst.
  - Once hlt_pending=1, every later MEM instruction is discarded as a bubble.
- Retired counter:
  - Increments by 1 on each edge where wb_valid=1, which includes the HALT slot.
  - It is not incremented again after hlt.
  - It wraps modulo 2^CNT_W.
- Simultaneous events:
  - flush beats mem_stall and mem_valid.
  - rst beats everything.
  - A HALT that arrives with flush asserted is discarded and does not set hlt_pending.
- State is only hlt_pending/hlt; no further FSM. The two-phase behaviour is RUN (hlt_pending=0) → DRAIN (hlt_pending=1, hlt=0) → HALTED (hlt=1), advancing one state per edge.

## Timing
- Latency: one cycle. A MEM instruction captured at edge N is visible on wb_* during cycle N..N+1 and is written to the register file at edge N+1.
- Throughput: one instruction per cycle with no stall.
- Load data passes through no extra register; mem_load_data must be settled before the capture edge.
- Reset values, on the first edge with rst=1:
  - All wb_* outputs, fwd_* outputs, hlt, hlt_pending and retired are 0.
  - rst held for several cycles keeps them at 0.
  - rst asserted mid-stream, including while HALTED, returns to RUN with retired=0.
- Outputs are registered and glitch-free relative to clk, except fwd_*, which are direct register copies.

## Test plan
- Back-to-back ALU ops:
  - Stimulus: R3←0x1234 at PC 0x0010, then R5←0xBEEF at PC 0x0012.
  - Required response: wb_reg_write=1 for two consecutive cycles with (3,0x1234) then (5,0xBEEF); retired=2.
- Load and store:
  - Stimulus: load with alu_result=0x0040 and load_data=0xCAFE to R2, then store of 0x00AA to 0x0042.
  - Required response, load cycle: wb_data=0xCAFE, wb_mem_read=1, wb_mem_addr=0x0040.
  - Required response, store cycle: wb_reg_write=0, wb_mem_write=1, wb_mem_data=0x00AA.
- R0 write suppression:
  - Stimulus: reg_write to dst=0 with value 0xFFFF.
  - Required response: wb_valid=1, wb_reg_write=0, fwd_valid=0, retired increments.
- Stall and flush:
  - Stimulus: mem_valid=1 with mem_stall=1 for 2 cycles, then flush=1 with mem_halt=1.
  - Required response: three bubbles (wb_valid=0); hlt stays 0; retired unchanged.
- Halt drain:
  - Stimulus: HALT at PC 0x0020, followed immediately by a valid R4 write.
  - Required response: wb_valid=1 with wb_pc=0x0020; hlt=1 on the next cycle; the R4 write never appears; retired frozen.
- Reset mid-operation:
  - Stimulus: assert rst for one edge while HALTED with retired=7.
  - Required response: all outputs 0; the next valid instruction commits normally; retired=1.
